// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension pipeline.
// Mode encodings match the 2-bit in_mode port.
`timescale 1ns/1ps
package imm_ext_pkg;

   typedef enum logic [1:0] {
      SEXT = 2'b00,
      ZEXT = 2'b01,
      LDHI = 2'b10,
      RSVD = 2'b11
   } imm_mode_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational extension of a pre-masked immediate field to a datapath word.
// Expects field bits at positions >= len to already be zero.
`timescale 1ns/1ps
module imm_ext_core
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = 9,
   parameter int OUT_W = 16,
   parameter int LEN_W = $clog2(IN_W + 1)
) (
   input  logic [IN_W-1:0]  field,
   input  logic [LEN_W-1:0] len,
   input  imm_mode_e        mode,
   output logic [OUT_W-1:0] word,
   output logic             err
);

   localparam int SH_W = $clog2(OUT_W + 1);

   logic [OUT_W-1:0] zext_s;
   logic [OUT_W-1:0] sign_fill_s;
   logic [OUT_W-1:0] probe_s;
   logic [SH_W-1:0]  hi_shift_s;
   logic             sign_s;

   // Mode-selected extension; the sign bit is found by shifting bit len-1 down to bit 0.
   always_comb begin
      zext_s      = OUT_W'(field);
      sign_fill_s = {OUT_W{1'b1}} << len;
      hi_shift_s  = SH_W'(OUT_W) - SH_W'(len);
      if (len != {LEN_W{1'b0}}) begin
         probe_s = zext_s >> (len - LEN_W'(1'b1));
         sign_s  = probe_s[0];
      end else begin
         probe_s = {OUT_W{1'b0}};
         sign_s  = 1'b0;
      end
      word = {OUT_W{1'b0}};
      err  = 1'b0;
      case (mode)
         SEXT: word = sign_s ? (zext_s | sign_fill_s) : zext_s;
         ZEXT: word = zext_s;
         LDHI: word = zext_s << hi_shift_s;
         RSVD: begin
            word = {OUT_W{1'b0}};
            err  = 1'b1;
         end
         default: begin
            word = {OUT_W{1'b0}};
            err  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/imm_ext_pipe.sv
// Two-stage valid/ready immediate extender: S1 holds the masked field, S2 the result.
// Latency 2, one result per cycle when out_ready stays high.
`timescale 1ns/1ps
module imm_ext_pipe
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = 9,
   parameter int OUT_W = 16,
   parameter int LEN_W = $clog2(IN_W + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [LEN_W-1:0] in_len,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_err
);

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(IN_W);

   logic             s1_valid_r;
   logic [IN_W-1:0]  s1_field_r;
   logic [LEN_W-1:0] s1_len_r;
   imm_mode_e        s1_mode_r;
   logic             s2_valid_r;
   logic [OUT_W-1:0] s2_data_r;
   logic             s2_err_r;

   logic             s2_open_s;
   logic             accept_s;
   logic [LEN_W-1:0] len_eff_s;
   logic [IN_W-1:0]  field_s;
   logic [OUT_W-1:0] core_word_s;
   logic             core_err_s;

   // Handshake and input masking; in_ready never looks at in_valid.
   always_comb begin
      s2_open_s = !s2_valid_r || out_ready;
      in_ready  = !flush && (!s1_valid_r || s2_open_s);
      accept_s  = in_valid && in_ready;
      if (in_len > LEN_MAX) begin
         len_eff_s = LEN_MAX;
      end else begin
         len_eff_s = in_len;
      end
      field_s = in_imm & ~({IN_W{1'b1}} << len_eff_s);
   end

   // Stage 1: capture on acceptance, empty when advancing without a refill.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_field_r <= {IN_W{1'b0}};
         s1_len_r   <= {LEN_W{1'b0}};
         s1_mode_r  <= SEXT;
      end else if (flush) begin
         s1_valid_r <= 1'b0;
      end else if (accept_s) begin
         s1_valid_r <= 1'b1;
         s1_field_r <= field_s;
         s1_len_r   <= len_eff_s;
         s1_mode_r  <= imm_mode_e'(in_mode);
      end else if (s2_open_s) begin
         s1_valid_r <= 1'b0;
      end
   end

   imm_ext_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .LEN_W (LEN_W)
   ) u_core (
      .field (s1_field_r),
      .len   (s1_len_r),
      .mode  (s1_mode_r),
      .word  (core_word_s),
      .err   (core_err_s)
   );

   // Stage 2: load whenever it is empty or draining; otherwise hold for the consumer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_r <= 1'b0;
         s2_data_r  <= {OUT_W{1'b0}};
         s2_err_r   <= 1'b0;
      end else if (flush) begin
         s2_valid_r <= 1'b0;
      end else if (s2_open_s) begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            s2_data_r <= core_word_s;
            s2_err_r  <= core_err_s;
         end
      end
   end

   assign out_valid = s2_valid_r;
   assign out_data  = s2_data_r;
   assign out_err   = s2_err_r;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed self-checking bench for imm_ext_pipe plus a random sweep of two other
// parameter sets against a bit-loop reference model.
`timescale 1ns/1ps
module tb_imm_ext_pipe;

   typedef struct {
      logic [8:0]  imm;
      logic [3:0]  len;
      logic [1:0]  mode;
      logic [15:0] data;
      logic        err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_err;
   logic [8:0]  in_imm;
   logic [3:0]  in_len;
   logic [1:0]  in_mode;
   logic [15:0] out_data;

   logic        p6_in_valid, p6_in_ready, p6_out_valid, p6_out_err;
   logic [5:0]  p6_in_imm;
   logic [2:0]  p6_in_len;
   logic [1:0]  p6_in_mode;
   logic [15:0] p6_out_data;

   logic        p11_in_valid, p11_in_ready, p11_out_valid, p11_out_err;
   logic [10:0] p11_in_imm;
   logic [3:0]  p11_in_len;
   logic [1:0]  p11_in_mode;
   logic [31:0] p11_out_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   imm_ext_pipe dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_len(in_len), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
   );

   imm_ext_pipe #(.IN_W(6), .OUT_W(16)) u6 (
      .clk(clk), .rst_n(rst_n), .flush(1'b0),
      .in_valid(p6_in_valid), .in_ready(p6_in_ready), .in_imm(p6_in_imm), .in_len(p6_in_len),
      .in_mode(p6_in_mode), .out_valid(p6_out_valid), .out_ready(1'b1),
      .out_data(p6_out_data), .out_err(p6_out_err)
   );

   imm_ext_pipe #(.IN_W(11), .OUT_W(32)) u11 (
      .clk(clk), .rst_n(rst_n), .flush(1'b0),
      .in_valid(p11_in_valid), .in_ready(p11_in_ready), .in_imm(p11_in_imm), .in_len(p11_in_len),
      .in_mode(p11_in_mode), .out_valid(p11_out_valid), .out_ready(1'b1),
      .out_data(p11_out_data), .out_err(p11_out_err)
   );

   // Reference: copy the low L bits one at a time, then extend per mode.
   function automatic logic [63:0] ref_ext(input int inw, input int outw, input logic [63:0] imm,
                                           input int len, input logic [1:0] mode);
      int l;
      logic [63:0] f, r;
      l = (len > inw) ? inw : len;
      f = 64'd0;
      r = 64'd0;
      for (int i = 0; i < l; i++) f[i] = imm[i];
      case (mode)
         2'b00: begin
            r = f;
            if (l > 0 && f[l-1]) for (int i = l; i < outw; i++) r[i] = 1'b1;
         end
         2'b01: r = f;
         2'b10: for (int i = 0; i < l; i++) r[outw-l+i] = f[i];
         default: r = 64'd0;
      endcase
      return r;
   endfunction

   // Present one request into an empty pipe and wait (bounded) for its result.
   task automatic apply(input logic [8:0] imm, input logic [3:0] len, input logic [1:0] mode,
                        output logic [15:0] d, output logic e, output int lat);
      @(negedge clk);
      in_imm = imm; in_len = len; in_mode = mode; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      d = out_data;
      e = out_err;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_imm = 9'd0; in_len = 4'd0; in_mode = 2'b00;
      p6_in_valid = 1'b0; p6_in_imm = 6'd0; p6_in_len = 3'd0; p6_in_mode = 2'b00;
      p11_in_valid = 1'b0; p11_in_imm = 11'd0; p11_in_len = 4'd0; p11_in_mode = 2'b00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
      n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b want 0", out_err); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic run_table(input string name, input vec_t v[]);
      logic [15:0] d;
      logic e;
      int lat;
      foreach (v[i]) begin
         apply(v[i].imm, v[i].len, v[i].mode, d, e, lat);
         n_checks++;
         if (lat !== 2) begin n_fail++; $display("FAIL %s_latency[%0d]: got %0d want 2", name, i, lat); end
         n_checks++;
         if (d !== v[i].data) begin n_fail++; $display("FAIL %s_data[%0d]: got %h want %h", name, i, d, v[i].data); end
         n_checks++;
         if (e !== v[i].err) begin n_fail++; $display("FAIL %s_err[%0d]: got %b want %b", name, i, e, v[i].err); end
      end
   endtask

   task automatic test_extend();
      vec_t v[] = '{
         '{9'h1F0, 4'd9, 2'b00, 16'hFFF0, 1'b0},
         '{9'h1F0, 4'd9, 2'b01, 16'h01F0, 1'b0},
         '{9'h1F0, 4'd9, 2'b10, 16'hF800, 1'b0},
         '{9'h00A, 4'd4, 2'b10, 16'hA000, 1'b0},
         '{9'h0F7, 4'd4, 2'b00, 16'h0007, 1'b0},
         '{9'h0FF, 4'd4, 2'b00, 16'hFFFF, 1'b0}
      };
      run_table("extend", v);
   endtask

   task automatic test_masking();
      vec_t v[] = '{
         '{9'h03F, 4'd6,  2'b00, 16'hFFFF, 1'b0},
         '{9'h03F, 4'd12, 2'b00, 16'h003F, 1'b0},
         '{9'h03F, 4'd0,  2'b00, 16'h0000, 1'b0},
         '{9'h1F0, 4'd0,  2'b10, 16'h0000, 1'b0},
         '{9'h1FF, 4'd15, 2'b10, 16'hFF80, 1'b0}
      };
      run_table("masking", v);
   endtask

   task automatic test_reserved();
      vec_t v[] = '{
         '{9'h1AB, 4'd9, 2'b11, 16'h0000, 1'b1},
         '{9'h001, 4'd9, 2'b00, 16'h0001, 1'b0}
      };
      run_table("reserved", v);
   endtask

   task automatic test_back_to_back();
      logic [8:0]  stim [10];
      logic [15:0] held;
      logic        stalled_prev, exp_ready, acc, con;
      int sent, recv, extra;
      for (int i = 0; i < 10; i++) stim[i] = 9'(i * 41 + 3);
      sent = 0; recv = 0; stalled_prev = 1'b0; held = 16'h0000;
      for (int cyc = 0; cyc < 400 && recv < 10; cyc++) begin
         @(negedge clk);
         if (stalled_prev) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== held) begin
               n_fail++;
               $display("FAIL stall_hold: got valid=%b data=%h want valid=1 data=%h", out_valid, out_data, held);
            end
         end
         out_ready = 1'($urandom_range(0, 1));
         in_valid  = (sent < 10);
         in_imm    = stim[(sent < 10) ? sent : 9];
         in_len    = 4'd9;
         in_mode   = 2'b01;
         #1;
         exp_ready = !((sent - recv) == 2 && !out_ready);
         n_checks++;
         if (in_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL bp_in_ready: got %b want %b (in flight %0d)", in_ready, exp_ready, sent - recv);
         end
         acc = in_valid && in_ready;
         con = out_valid && out_ready;
         if (con) begin
            n_checks++;
            if (recv >= 10 || out_data !== 16'(stim[recv])) begin
               n_fail++;
               $display("FAIL bp_order[%0d]: got %h want %h", recv, out_data, 16'(stim[(recv < 10) ? recv : 9]));
            end
            recv++;
         end
         if (acc) sent++;
         stalled_prev = out_valid && !out_ready;
         held = out_data;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n_checks++;
      if (recv !== 10) begin n_fail++; $display("FAIL bp_count: got %0d want 10", recv); end
      extra = 0;
      repeat (4) begin
         @(negedge clk);
         if (out_valid === 1'b1) extra++;
      end
      n_checks++;
      if (extra !== 0) begin n_fail++; $display("FAIL bp_duplicate: got %0d extra results want 0", extra); end
   endtask

   task automatic test_flush();
      logic [15:0] d;
      logic e;
      int lat, seen;
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_imm = 9'h011; in_len = 4'd9; in_mode = 2'b01;
      @(negedge clk);
      in_imm = 9'h022;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_setup: got out_valid=%b want 1", out_valid); end
      flush = 1'b1; in_imm = 9'h033;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      seen = 0;
      repeat (5) begin
         if (out_valid === 1'b1) seen++;
         @(negedge clk);
      end
      n_checks++;
      if (seen !== 0) begin n_fail++; $display("FAIL flush_drop: got %0d results want 0", seen); end
      apply(9'h055, 4'd9, 2'b01, d, e, lat);
      n_checks++;
      if (lat !== 2 || d !== 16'h0055) begin
         n_fail++; $display("FAIL flush_after: got lat=%0d data=%h want lat=2 data=0055", lat, d);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] d;
      logic e;
      int lat;
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_imm = 9'h0AA; in_len = 4'd9; in_mode = 2'b01;
      @(negedge clk);
      in_imm = 9'h0BB;
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_setup: got out_valid=%b want 1", out_valid); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 16'h0000 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_async: got valid=%b data=%h ready=%b want 0/0000/1", out_valid, out_data, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      apply(9'h0CC, 4'd9, 2'b01, d, e, lat);
      n_checks++;
      if (lat !== 2 || d !== 16'h00CC) begin
         n_fail++; $display("FAIL rst_after: got lat=%0d data=%h want lat=2 data=00CC", lat, d);
      end
   endtask

   task automatic test_sweep();
      logic [63:0] q6_d[$], q11_d[$];
      logic        q6_e[$], q11_e[$];
      int n6, n11, got6, got11;
      n6 = 0; n11 = 0; got6 = 0; got11 = 0;
      for (int cyc = 0; cyc < 3000 && (got6 < 1000 || got11 < 1000); cyc++) begin
         @(negedge clk);
         if (p6_out_valid === 1'b1) begin
            n_checks++;
            if (q6_d.size() == 0 || p6_out_data !== 16'(q6_d[0]) || p6_out_err !== q6_e[0]) begin
               n_fail++;
               $display("FAIL sweep6[%0d]: got %h/%b want %h/%b", got6, p6_out_data, p6_out_err,
                        (q6_d.size() != 0) ? 16'(q6_d[0]) : 16'h0, (q6_e.size() != 0) ? q6_e[0] : 1'b0);
            end
            if (q6_d.size() != 0) begin void'(q6_d.pop_front()); void'(q6_e.pop_front()); end
            got6++;
         end
         if (p11_out_valid === 1'b1) begin
            n_checks++;
            if (q11_d.size() == 0 || p11_out_data !== 32'(q11_d[0]) || p11_out_err !== q11_e[0]) begin
               n_fail++;
               $display("FAIL sweep11[%0d]: got %h/%b want %h/%b", got11, p11_out_data, p11_out_err,
                        (q11_d.size() != 0) ? 32'(q11_d[0]) : 32'h0, (q11_e.size() != 0) ? q11_e[0] : 1'b0);
            end
            if (q11_d.size() != 0) begin void'(q11_d.pop_front()); void'(q11_e.pop_front()); end
            got11++;
         end
         p6_in_valid  = (n6 < 1000);
         p6_in_imm    = 6'($urandom);
         p6_in_len    = 3'($urandom_range(0, 7));
         p6_in_mode   = 2'($urandom_range(0, 3));
         p11_in_valid = (n11 < 1000);
         p11_in_imm   = 11'($urandom);
         p11_in_len   = 4'($urandom_range(0, 15));
         p11_in_mode  = 2'($urandom_range(0, 3));
         #1;
         if (p6_in_valid && p6_in_ready) begin
            q6_d.push_back(ref_ext(6, 16, 64'(p6_in_imm), int'(p6_in_len), p6_in_mode));
            q6_e.push_back(p6_in_mode == 2'b11);
            n6++;
         end
         if (p11_in_valid && p11_in_ready) begin
            q11_d.push_back(ref_ext(11, 32, 64'(p11_in_imm), int'(p11_in_len), p11_in_mode));
            q11_e.push_back(p11_in_mode == 2'b11);
            n11++;
         end
      end
      p6_in_valid = 1'b0; p11_in_valid = 1'b0;
      n_checks++;
      if (got6 !== 1000 || got11 !== 1000) begin
         n_fail++; $display("FAIL sweep_count: got %0d/%0d want 1000/1000", got6, got11);
      end
   endtask

   initial begin
      test_reset();
      test_extend();
      test_masking();
      test_reserved();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 9, the maximum immediate field width.
REQ-002 SHALL have parameter OUT_W, default 16, the datapath word width; legal only when OUT_W > IN_W >= 1.
REQ-003 SHALL have parameter LEN_W, default $clog2(IN_W+1), the width of the length field.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port flush, input, 1 bit: synchronous pipeline clear.
REQ-007 SHALL have port in_valid, input, 1 bit: request valid.
REQ-008 SHALL have port in_ready, output, 1 bit: request accepted when in_valid && in_ready.
REQ-009 SHALL have port in_imm, input, IN_W bits: raw immediate, LSB-aligned.
REQ-010 SHALL have port in_len, input, LEN_W bits: number of meaningful LSBs of in_imm.
REQ-011 SHALL have port in_mode, input, 2 bits: 00 sign-extend, 01 zero-extend, 10 load-high, 11 reserved.
REQ-012 SHALL have port out_valid, output, 1 bit: result valid.
REQ-013 SHALL have port out_ready, input, 1 bit: result consumed when out_valid && out_ready.
REQ-014 SHALL have port out_data, output, OUT_W bits: extended word.
REQ-015 SHALL have port out_err, output, 1 bit: qualifies out_data; set for reserved mode.

Function
REQ-016 SHALL implement two register stages: S1 captures the masked field, effective length and mode; S2 registers the extended result.
REQ-017 SHALL produce out_valid two cycles after acceptance when out_ready is held high, with latency 2 and throughput 1 per cycle.
REQ-018 SHALL set effective length L = min(in_len, IN_W); bits of in_imm at positions >= L are ignored (masked to 0).
REQ-019 SHALL, in mode 00, set out_data = field sign-extended from bit L-1 to OUT_W.
REQ-020 SHALL, in mode 01, set out_data = field zero-extended.
REQ-021 SHALL, in mode 10, set out_data = field << (OUT_W-L); low bits are 0.
REQ-022 SHALL, in mode 11, set out_data = 0 and out_err = 1; out_err SHALL be 0 in all other modes.
REQ-023 SHALL, when L = 0, set out_data = 0 for all modes; out_err follows REQ-022.
REQ-024 SHALL hold S2 and keep out_data/out_err stable while out_valid && !out_ready.
REQ-025 SHALL advance S1 to S2 when S2 is empty or drains in the same cycle.
REQ-026 SHALL drive in_ready = !S1.valid || S1 advances this cycle; in_ready SHALL depend combinationally on out_ready only (no dependency on in_valid).
REQ-027 SHALL, on simultaneous drain of S2, advance of S1 and acceptance of new input, lose no transaction and duplicate none.
REQ-028 SHALL, when flush = 1, clear both stage valids at the next edge, ignore same-cycle input acceptance, and drive in_ready = 0 during flush.
REQ-029 SHALL not alter the data registers of invalid stages in any way visible at the outputs.

Reset
REQ-030 SHALL, while rst_n = 0, immediately clear S1.valid and S2.valid, set out_valid = 0, out_data = 0 and out_err = 0; in_ready SHALL be 1 after reset.
REQ-031 SHALL discard any in-flight transaction on reset mid-operation; the first post-reset result SHALL come from a post-reset acceptance.

Structure
REQ-032 SHALL place the mode encodings (SEXT, ZEXT, LDHI, RSVD) in shared package imm_ext_pkg.
REQ-033 SHALL place the extension arithmetic in one combinational sub-module imm_ext_core (field, L, mode -> word, err), parametrised by IN_W/OUT_W, instanced between S1 and S2.
REQ-034 SHALL contain no other sub-modules; the handshake logic lives in imm_ext_pipe.

Verification
REQ-035 SHALL cover default params: imm=9'h1F0, len=9, mode 00 -> out_data 16'hFFF0 at cycle +2; mode 01 -> 16'h01F0; mode 10 -> 16'hF800.
REQ-036 SHALL cover length masking: imm=9'h03F, len=6, mode 00 -> 16'hFFFF; len=12 (clamped to 9) -> 16'h003F; len=0 -> 16'h0000.
REQ-037 SHALL cover reserved mode: mode 11, any imm -> out_data 0, out_err 1; next mode-00 result out_err 0.
REQ-038 SHALL cover backpressure: stream 10 back-to-back requests with out_ready toggling randomly -> all 10 results in order, no loss or duplication, out_data stable while stalled, in_ready low only when both stages are full and out_ready is low.
REQ-039 SHALL cover flush and reset: flush with 2 in flight -> no out_valid for those; rst_n pulsed low mid-stream -> out_valid drops asynchronously, and a single post-reset request returns after 2 cycles.
REQ-040 SHALL cover parameter sweep: IN_W=6/OUT_W=16 and IN_W=11/OUT_W=32 against a reference model with 1000 random requests -> zero mismatches.
